// File: rtl/commit_trace_tx.sv
// Retirement trace transmitter: queues MEM/WB retire records and streams them LSB-first as bytes.
// Define TRACE_CYCLE_STAMP_EN to append a 32-bit cycle stamp (13-byte records instead of 9).
module commit_trace_tx #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wb_valid,
    input  logic [31:0]            wb_pc,
    input  logic [4:0]             wb_rd,
    input  logic                   wb_we,
    input  logic [31:0]            wb_data,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic                   tx_last,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic [CNT_W-1:0]       drop_count,
    output logic                   busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
`ifdef TRACE_CYCLE_STAMP_EN
    localparam logic STAMP_BIT = 1'b1;
`else
    localparam logic STAMP_BIT = 1'b0;
`endif

    typedef struct packed {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] data;
`ifdef TRACE_CYCLE_STAMP_EN
        logic [31:0] stamp;
`endif
    } rec_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_PC,
        S_DATA,
        S_STMP
    } state_t;

    rec_t          mem_q [DEPTH];
    rec_t          wr_rec;
    rec_t          cur_q;
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [LW-1:0] level_q;
    logic [LW-1:0] level_d;
    logic [CNT_W-1:0] drop_q;
    state_t        state_q;
    state_t        state_d;
    logic [1:0]    idx_q;
    logic [1:0]    idx_d;
    logic          full;
    logic          push;
    logic          drop;
    logic          pop;
    logic          accept;
    logic          rec_end;
    logic          fifo_nonempty;

`ifdef TRACE_CYCLE_STAMP_EN
    logic [31:0]   cyc_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cyc_q <= 32'd0;
        end else begin
            cyc_q <= cyc_q + 32'd1;
        end
    end
`endif

    // Full is judged on the level at the start of the cycle, so a same-cycle pop cannot rescue a push.
    assign full          = (level_q == FULL_LVL);
    assign fifo_nonempty = (level_q != '0);
    assign push          = wb_valid && !full;
    assign drop          = wb_valid && full;
    assign accept        = tx_valid && tx_ready;
    assign rec_end       = accept && tx_last;
    assign pop           = fifo_nonempty && ((state_q == S_IDLE) || rec_end);

    always_comb begin
        wr_rec      = '0;
        wr_rec.we   = wb_we && (wb_rd != 5'd0);
        wr_rec.rd   = wb_rd;
        wr_rec.pc   = wb_pc;
        wr_rec.data = wb_data;
`ifdef TRACE_CYCLE_STAMP_EN
        wr_rec.stamp = cyc_q;
`endif
    end

    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_rec;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            drop_q   <= '0;
            cur_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
                cur_q    <= mem_q[rd_ptr_q];
            end
            level_q <= level_d;
            if (drop && (drop_q != '1)) begin
                drop_q <= drop_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            idx_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                idx_d = 2'd0;
                if (fifo_nonempty) begin
                    state_d = S_HDR;
                end
            end
            S_HDR: begin
                if (accept) begin
                    state_d = S_PC;
                    idx_d   = 2'd0;
                end
            end
            S_PC: begin
                if (accept) begin
                    if (idx_q == 2'd3) begin
                        state_d = S_DATA;
                        idx_d   = 2'd0;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    if (idx_q == 2'd3) begin
                        idx_d = 2'd0;
`ifdef TRACE_CYCLE_STAMP_EN
                        state_d = S_STMP;
`else
                        state_d = fifo_nonempty ? S_HDR : S_IDLE;
`endif
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            S_STMP: begin
                if (accept) begin
                    if (idx_q == 2'd3) begin
                        idx_d   = 2'd0;
                        state_d = fifo_nonempty ? S_HDR : S_IDLE;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = 2'd0;
            end
        endcase
    end

    // Outputs depend only on registered state, so they hold steady while the sink stalls.
    always_comb begin
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        tx_data  = 8'h00;
        case (state_q)
            S_HDR: begin
                tx_valid = 1'b1;
                tx_data  = {cur_q.we, STAMP_BIT, 1'b0, cur_q.rd};
            end
            S_PC: begin
                tx_valid = 1'b1;
                tx_data  = cur_q.pc[{idx_q, 3'b000} +: 8];
            end
            S_DATA: begin
                tx_valid = 1'b1;
                tx_data  = cur_q.data[{idx_q, 3'b000} +: 8];
`ifndef TRACE_CYCLE_STAMP_EN
                tx_last  = (idx_q == 2'd3);
`endif
            end
`ifdef TRACE_CYCLE_STAMP_EN
            S_STMP: begin
                tx_valid = 1'b1;
                tx_data  = cur_q.stamp[{idx_q, 3'b000} +: 8];
                tx_last  = (idx_q == 2'd3);
            end
`endif
            default: begin
                tx_valid = 1'b0;
                tx_last  = 1'b0;
                tx_data  = 8'h00;
            end
        endcase
    end

    assign fifo_level = level_q;
    assign drop_count = drop_q;
    assign busy       = (state_q != S_IDLE) || fifo_nonempty;

endmodule
